// File: rtl/dram_bram_drain_pkg.sv
// Shared definitions for the BRAM drain stage: FSM encodings, pointer width
// helper and parameter range checks.
package dram_bram_drain_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam int GAP_MAX = 255;

  // One extra bit lets full and empty be told apart when the address bits match.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic bit pkt_len_ok(input int pkt_len, input int depth);
    return (pkt_len >= 1) && (pkt_len <= depth);
  endfunction

  function automatic bit gap_cyc_ok(input int gap_cyc);
    return (gap_cyc >= 0) && (gap_cyc <= GAP_MAX);
  endfunction

endpackage

// File: rtl/dram_bram_drain_sdp_bram.sv
// Simple dual-port RAM: one write port, one registered read port, no array reset.
module sdp_bram #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dram_bram_drain.sv
// Circular BRAM buffer fed by the DRAM reader, drained as fixed-length packets
// on a valid/ready stream with a forced idle gap between packets.
module dram_bram_drain
  import dram_bram_drain_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 9,
  parameter int PKT_LEN = 64,
  parameter int GAP_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_bram,
  input  logic [DATA_W-1:0] wr_data,
  output logic              bram_full,
  output logic [ADDR_W:0]   fill_level,
  input  logic              en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_eof,
  output logic [31:0]       pkt_count,
  output logic              overflow
);

  localparam int PTR_W = ptr_w(ADDR_W);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [PTR_W-1:0] DEPTH_L   = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PKT_LEN_L = PTR_W'(PKT_LEN);
  localparam logic [PTR_W-1:0] PKT_LAST  = PTR_W'(PKT_LEN - 1);
  localparam logic [7:0]       GAP_LAST  = 8'(GAP_CYC - 1);

  if (!pkt_len_ok(PKT_LEN, DEPTH)) begin : g_bad_pkt_len
    $error("dram_bram_drain: PKT_LEN must be 1..2**ADDR_W");
  end
  if (!gap_cyc_ok(GAP_CYC)) begin : g_bad_gap_cyc
    $error("dram_bram_drain: GAP_CYC must be 0..255");
  end

  logic [PTR_W-1:0]  wr_ptr, rd_ptr, level;
  logic [PTR_W-1:0]  wr_ptr_nxt, rd_ptr_nxt;
  logic              wr_acc, rd_issue;
  logic [1:0]        state, state_nxt;
  logic [PTR_W-1:0]  iss_cnt;
  logic [7:0]        gap_cnt;
  logic [DATA_W-1:0] bram_rdata;
  logic              bram_vld_p1, bram_eof_p1;
  logic [DATA_W-1:0] skid_data_p2;
  logic              skid_vld_p2, skid_eof_p2;
  logic              eof_hs, out_free, room;
  logic [1:0]        occ;

  assign bram_full  = (level == DEPTH_L);
  assign fill_level = level;
  assign wr_acc     = write_bram && !bram_full;
  assign wr_ptr_nxt = wr_ptr + PTR_W'(wr_acc);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(rd_issue);
  assign eof_hs     = out_valid && out_ready && out_eof;
  assign out_free   = !out_valid || out_ready;

  // Words already committed past the output slot; a new read may issue only
  // while the output register plus skid can still absorb it.
  assign occ  = {1'b0, out_valid && !out_ready} + {1'b0, skid_vld_p2} + {1'b0, bram_vld_p1};
  assign room = (occ < 2'd2);

  sdp_bram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wr_data),
    .re    (rd_issue),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (bram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      level    <= wr_ptr_nxt - rd_ptr_nxt;
      overflow <= overflow | (write_bram && bram_full);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_WAIT;
      ST_WAIT: if (en && (level >= PKT_LEN_L)) state_nxt = ST_SEND;
      ST_SEND: if (eof_hs) state_nxt = (GAP_CYC == 0) ? ST_WAIT : ST_GAP;
      ST_GAP:  if (gap_cnt == GAP_LAST) state_nxt = ST_WAIT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reads are pre-committed: the level check on entry guarantees PKT_LEN words.
  always_comb begin
    rd_issue = 1'b0;
    if ((state == ST_SEND) && (iss_cnt != PKT_LEN_L) && room) rd_issue = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_cnt   <= '0;
      gap_cnt   <= '0;
      pkt_count <= '0;
    end else begin
      if (state != ST_SEND) iss_cnt <= '0;
      else if (rd_issue)    iss_cnt <= iss_cnt + 1'b1;
      if (state != ST_GAP)  gap_cnt <= '0;
      else                  gap_cnt <= gap_cnt + 8'd1;
      pkt_count <= pkt_count + 32'(eof_hs);
    end
  end

  // p1: BRAM registered read, eof tag travels with the read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_vld_p1 <= 1'b0;
      bram_eof_p1 <= 1'b0;
    end else begin
      bram_vld_p1 <= rd_issue;
      bram_eof_p1 <= rd_issue && (iss_cnt == PKT_LAST);
    end
  end

  // p2: output register with a one-deep skid behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_eof     <= 1'b0;
      skid_vld_p2 <= 1'b0;
      skid_eof_p2 <= 1'b0;
    end else if (out_free) begin
      if (skid_vld_p2) begin
        out_data    <= skid_data_p2;
        out_eof     <= skid_eof_p2;
        out_valid   <= 1'b1;
        skid_vld_p2 <= bram_vld_p1;
        skid_eof_p2 <= bram_eof_p1;
      end else if (bram_vld_p1) begin
        out_data    <= bram_rdata;
        out_eof     <= bram_eof_p1;
        out_valid   <= 1'b1;
      end else begin
        out_valid   <= 1'b0;
        out_eof     <= 1'b0;
      end
    end else if (bram_vld_p1) begin
      skid_vld_p2 <= 1'b1;
      skid_eof_p2 <= bram_eof_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (bram_vld_p1 && (!out_free || skid_vld_p2)) skid_data_p2 <= bram_rdata;
  end

endmodule

// File: tb/tb_dram_bram_drain.sv
// Directed bench for dram_bram_drain with a queue-based stream model.
module tb_dram_bram_drain;

  logic        clk;
  logic        rst_n;
  logic        write_bram;
  logic [63:0] wr_data;
  logic        bram_full;
  logic [4:0]  fill_level;
  logic        en;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_eof;
  logic [31:0] pkt_count;
  logic        overflow;

  dram_bram_drain #(
    .DATA_W  (64),
    .ADDR_W  (4),
    .PKT_LEN (4),
    .GAP_CYC (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_bram (write_bram),
    .wr_data    (wr_data),
    .bram_full  (bram_full),
    .fill_level (fill_level),
    .en         (en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_eof    (out_eof),
    .pkt_count  (pkt_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: words accepted but not yet delivered, packet position, totals.
  logic [63:0] exp_q[$];
  logic [63:0] log_q[$];
  int          hs_in_pkt  = 0;
  int          pkts_model = 0;
  int          hs_total   = 0;
  bit          prev_stall = 0;
  logic [63:0] prev_data;
  logic        prev_eof;
  bit          in_gap = 0;
  int          gap_idle = 0;
  bit          rdy_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stream checker, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pkt_count", 64'(pkt_count), 64'(pkts_model));
      if (!out_valid) chk("eof_without_valid", 64'(out_eof), 64'd0);
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", out_data, prev_data);
        chk("stall_eof", 64'(out_eof), 64'(prev_eof));
      end
      if (in_gap) begin
        if (out_valid) begin
          chk("gap_idle_ge2", 64'(gap_idle >= 2), 64'd1);
          in_gap = 0;
        end else begin
          gap_idle++;
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", out_data, 64'hDEAD);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
        chk("out_eof", 64'(out_eof), 64'(hs_in_pkt == 3));
        log_q.push_back(out_data);
        hs_total++;
        hs_in_pkt = (hs_in_pkt + 1) % 4;
        if (hs_in_pkt == 0) begin
          pkts_model++;
          in_gap   = 1;
          gap_idle = 0;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_eof   = out_eof;
    end
  end

  // Sink ready: always high, or the repeating 1,0,0,1 pattern.
  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) begin
        out_ready = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [63:0] d, input bit accept);
    write_bram = 1'b1;
    wr_data    = d;
    @(posedge clk);
    #1;
    write_bram = 1'b0;
    if (accept) exp_q.push_back(d);
  endtask

  task automatic wait_pkts(input int target, input int budget, input string nm);
    int n;
    n = 0;
    while (pkts_model < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (pkts_model < target) begin
      errors++;
      $display("FAIL %s: timeout, packets %0d expected %0d", nm, pkts_model, target);
    end
  endtask

  task automatic wait_valid(input int budget, input string nm, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s: timeout waiting for out_valid after %0d cycles", nm, cyc);
    end
  endtask

  initial begin
    int cyc;
    int base;
    int sent;
    int vcount;

    rst_n      = 1'b1;
    en         = 1'b0;
    write_bram = 1'b0;
    wr_data    = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_eof", 64'(out_eof), 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_fill_level", 64'(fill_level), 64'd0);
    chk("reset_bram_full", 64'(bram_full), 64'd0);
    chk("reset_pkt_count", 64'(pkt_count), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single packet, latency and back-to-back delivery
    en = 1'b1;
    for (int i = 0; i < 4; i++) wr(64'(i), 1'b1);
    wait_valid(20, "t1_first_valid", cyc);
    chk("t1_latency", 64'(cyc), 64'd3);
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid_run", 64'(out_valid), 64'd1);
      chk("t1_data_run", out_data, 64'(i));
      @(posedge clk);
      #1;
    end
    chk("t1_valid_drop", 64'(out_valid), 64'd0);
    wait_pkts(1, 50, "t1_pkt");
    chk("t1_pkt_count", 64'(pkt_count), 64'd1);
    chk("t1_level", 64'(fill_level), 64'd0);
    for (int i = 0; i < 4; i++) chk("t1_log", log_q[i], 64'(i));

    // 2: fill to full with drain disabled, overflow, then drain
    en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) wr(64'(i), 1'b1);
    chk("t2_not_full_15", 64'(bram_full), 64'd0);
    chk("t2_level_15", 64'(fill_level), 64'd15);
    wr(64'd15, 1'b1);
    chk("t2_full_16", 64'(bram_full), 64'd1);
    chk("t2_level_16", 64'(fill_level), 64'd16);
    chk("t2_no_overflow_yet", 64'(overflow), 64'd0);
    wr(64'hBAD0, 1'b0);
    chk("t2_overflow", 64'(overflow), 64'd1);
    chk("t2_level_held", 64'(fill_level), 64'd16);
    en = 1'b1;
    wait_pkts(5, 400, "t2_drain");
    for (int i = 0; i < 16; i++) chk("t2_log", log_q[4 + i], 64'(i));
    chk("t2_empty", 64'(fill_level), 64'd0);
    chk("t2_overflow_sticky", 64'(overflow), 64'd1);

    // 3: sink stalls with ready pattern 1,0,0,1
    base = hs_total;
    rdy_mode = 1'b1;
    for (int i = 0; i < 8; i++) wr(64'(100 + i), 1'b1);
    wait_pkts(pkts_model + 2, 400, "t3_drain");
    chk("t3_handshakes", 64'(hs_total - base), 64'd8);
    rdy_mode = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 4: continuous streaming across pointer wrap
    sent = 0;
    cyc  = 0;
    base = pkts_model;
    while (sent < 36 && cyc < 3000) begin
      if (exp_q.size() < 12) begin
        wr(64'(200 + sent), 1'b1);
        sent++;
      end else begin
        @(posedge clk);
        #1;
      end
      cyc++;
    end
    chk("t4_all_sent", 64'(sent), 64'd36);
    wait_pkts(base + 9, 600, "t4_drain");
    chk("t4_empty", 64'(fill_level), 64'd0);

    // 5: drop en mid-packet
    base = pkts_model;
    for (int i = 0; i < 4; i++) wr(64'(300 + i), 1'b1);
    cyc = 0;
    while (hs_in_pkt != 2 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("t5_reached_word2", 64'(hs_in_pkt), 64'd2);
    en = 1'b0;
    for (int i = 4; i < 8; i++) wr(64'(300 + i), 1'b1);
    wait_pkts(base + 1, 50, "t5_finish");
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      vcount += int'(out_valid);
    end
    chk("t5_no_valid_while_off", 64'(vcount), 64'd0);
    chk("t5_level_waiting", 64'(fill_level), 64'd4);
    en = 1'b1;
    wait_pkts(base + 2, 100, "t5_resume");

    // 6: asynchronous reset mid-packet
    for (int i = 0; i < 4; i++) wr(64'(400 + i), 1'b1);
    wait_valid(30, "t6_first_valid", cyc);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    chk("t6_async_level", 64'(fill_level), 64'd0);
    chk("t6_async_pkt_count", 64'(pkt_count), 64'd0);
    chk("t6_async_overflow", 64'(overflow), 64'd0);
    chk("t6_async_eof", 64'(out_eof), 64'd0);
    exp_q.delete();
    hs_in_pkt  = 0;
    pkts_model = 0;
    prev_stall = 0;
    in_gap     = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t6_level_after", 64'(fill_level), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    base = log_q.size();
    for (int i = 0; i < 4; i++) wr(64'(500 + i), 1'b1);
    wait_pkts(1, 50, "t6_resume");
    chk("t6_pkt_count", 64'(pkt_count), 64'd1);
    chk("t6_first_word", log_q[base], 64'd500);
    chk("t6_last_word", log_q[base + 3], 64'd503);
    repeat (5) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
